// File: rtl/pl_instmem.sv
// ============================================================================
//  Module      : pl_instmem
//  Description : Programmable instruction memory with a registered fetch port,
//                stall hold, fault flagging, a program-load port and a
//                NOP-fill init sequencer that runs after every reset.
//                Optional macro INSTMEM_BYPASS_EN forwards a same-cycle
//                program write to a fetch of the same word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pl_instmem #(
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 32'h00000000
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    input  logic              f_stall,
    output logic              f_ready,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_inst,
    output logic              f_fault,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ack
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [ADDR_W-1:0]   cnt_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                running;
    logic [ADDR_W-1:0]   fetch_idx;
    logic                fetch_fault;
    logic [DATA_W-1:0]   rd_data;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign running     = (state == RUN);
    assign f_ready     = running;
    assign fetch_idx   = f_addr[ADDR_W+1:2];
    // Any address bit above the word index means the fetch lies beyond DEPTH.
    assign fetch_fault = (f_addr[1:0] != 2'b00) || ((f_addr >> (ADDR_W + 2)) != 32'd0);

`ifdef INSTMEM_BYPASS_EN
    assign rd_data = (p_we && running && (p_addr == fetch_idx)) ? p_data : mem[fetch_idx];
`else
    assign rd_data = mem[fetch_idx];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = p_addr;
        mem_wdata = p_data;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = NOP_WORD;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_we = p_we;
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= INIT;
            cnt     <= '0;
            f_valid <= 1'b0;
            f_inst  <= '0;
            f_fault <= 1'b0;
            p_ack   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            p_ack <= running && p_we;
            if (running && !f_stall) begin
                if (f_req) begin
                    f_valid <= 1'b1;
                    f_fault <= fetch_fault;
                    f_inst  <= fetch_fault ? NOP_WORD : rd_data;
                end else begin
                    f_valid <= 1'b0;
                    f_fault <= 1'b0;
                end
            end
        end
    end

    // Storage has no reset; the init sequencer overwrites every word instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

`default_nettype wire

// File: doc/pl_instmem.md
Name: pl_instmem

Overview:
Parametrised, synchronous, programmable instruction memory for the pipelined CPU, replacing the fixed combinational 32-word ROM. It has a one-cycle registered fetch port with stall hold, and flags misaligned or out-of-range fetches. A program-load port lets the boot loader or testbench write instruction words. After reset, an init sequencer fills every word with NOP_WORD before fetches are accepted.

Parameters:
ADDR_W, 5, word-address bits; DEPTH = 2**ADDR_W words (default 32 words = 128 bytes)
DATA_W, 32, instruction width in bits
NOP_WORD, 32'h00000000, fill value after reset and value returned on fault (sll r0,r0,0)

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
f_req  in  1  fetch request
f_addr  in  32  fetch byte address
f_stall  in  1  hold fetch outputs
f_ready  out  1  1 = init complete, fetches accepted
f_valid  out  1  f_inst valid this cycle
f_inst  out  DATA_W  fetched instruction
f_fault  out  1  fetch was misaligned or out of range
p_we  in  1  program write enable
p_addr  in  ADDR_W  program word address
p_data  in  DATA_W  program write data
p_ack  out  1  write accepted (registered, one cycle after p_we)

Behaviour:
- Reset is asynchronous and active-low. Clock port is clk; reset port is clrn.
- clrn low, applied asynchronously: state=INIT, init counter=0, f_ready=0, f_valid=0, f_inst=0, f_fault=0, p_ack=0.
- FSM states are INIT and RUN.
- INIT: each clk writes NOP_WORD to mem[cnt], then cnt++. After the write of word DEPTH-1, go to RUN.
  - f_ready rises on the DEPTH-th rising edge after clrn deasserts.
  - f_req and p_we are ignored in INIT; f_valid=0, p_ack=0.
- RUN: no exit except reset.
- Fetch, latency 1 cycle:
  - f_req=1, f_stall=0 at edge N: at N+1, f_valid=1 and f_inst=mem[f_addr[ADDR_W+1:2]].
  - f_stall=1: f_valid, f_inst and f_fault hold their values, whatever f_req/f_addr are.
  - f_req=0, f_stall=0: f_valid=0, f_fault=0, f_inst holds its last value.
- Fault, evaluated on an accepted request:
  - Condition: f_addr[1:0]!=0 (misaligned), or f_addr[31:ADDR_W+2]!=0 (beyond DEPTH).
  - Response: f_valid=1, f_fault=1, f_inst=NOP_WORD; memory is not read.
- Program write:
  - In RUN, p_we=1 at an edge writes mem[p_addr]<=p_data.
  - p_ack=1 for one cycle after each accepted write, otherwise 0.
  - Back-to-back writes are accepted every cycle.
- Simultaneous fetch and write to the same word: the fetch returns the old contents (read-before-write), unless the optional feature is enabled.
- Address wrap: none. Out-of-range is a fault, never aliased. p_addr always covers DEPTH exactly.
- Reset mid-operation: aborts the init count or any fetch/write immediately. All programmed contents are lost; INIT re-runs a full DEPTH cycles.
- No combinational path from any input to any output.

Optional Feature:
INSTMEM_BYPASS_EN
- Defined: a fetch accepted in the same cycle as a RUN write to the same word returns p_data (write-to-read forwarding). f_fault is unaffected.
- Undefined: that fetch returns the pre-write contents.

Test Plan:
1. Reset, ADDR_W=5: release clrn. f_ready=0 for 32 cycles and =1 from edge 32. Fetch 0x10 -> f_valid=1, f_inst=0x00000000, f_fault=0 one cycle later.
2. Write and read back: p_we, p_addr=3, p_data=0x0c000018 -> p_ack=1 next cycle. Then fetch f_addr=0x0c -> f_inst=0x0c000018, f_valid=1, f_fault=0.
3. Faults:
   - f_addr=0x80 -> f_fault=1, f_inst=0x00000000, f_valid=1.
   - f_addr=0x06 -> f_fault=1.
   - Next idle cycle -> f_valid=0, f_fault=0.
4. Stall hold: fetch 0x0c (0x0c000018), then f_stall=1 for 3 cycles while f_addr=0x10, f_req=1 -> outputs hold 0x0c000018/valid=1 for all 3 cycles. Release -> mem[4] appears next cycle.
5. Same-cycle conflict: p_we, p_addr=4, p_data=0xac820000, and fetch f_addr=0x10 in the same cycle.
   - Without the macro: f_inst=0x00000000.
   - With INSTMEM_BYPASS_EN: f_inst=0xac820000.
   - A following fetch of 0x10 returns 0xac820000 in both builds.
6. Reset mid-run: pulse clrn low during valid output.
   - All outputs go 0 immediately without a clock edge; f_ready=0.
   - Re-init takes 32 cycles; fetch 0x0c then returns 0x00000000.
   - A p_we issued during re-init gives no p_ack.
